// File: rtl/stage_seq_pkg.sv
// Shared constants and types for the stage sequencer and its decode helper.
package stage_seq_pkg;

   // Stage index values seen by StageTracker
   localparam logic [2:0] STAGE_IDLE      = 3'd0;
   localparam logic [2:0] STAGE_FETCH     = 3'd1;
   localparam logic [2:0] STAGE_DECODE    = 3'd2;
   localparam logic [2:0] STAGE_EXECUTE   = 3'd3;
   localparam logic [2:0] STAGE_MEMORY    = 3'd4;
   localparam logic [2:0] STAGE_WRITEBACK = 3'd5;

   // Sequencer control states
   typedef enum logic [1:0] {
      FSM_IDLE   = 2'd0,
      FSM_RUN    = 2'd1,
      FSM_HALTED = 2'd2
   } fsm_state_e;

   // Default opcode map and counter width
   localparam int         OPCODE_W_DEF     = 4;
   localparam logic [3:0] NOP_OPCODE_DEF   = 4'h0;
   localparam logic [3:0] STORE_OPCODE_DEF = 4'h3;
   localparam logic [3:0] HALT_OPCODE_DEF  = 4'hF;
   localparam int         ICOUNT_W_DEF     = 16;

endpackage

// File: rtl/opcode_flag_decode.sv
// Combinational opcode classifier: flags NOP, STORE and HALT opcodes.
module opcode_flag_decode
   import stage_seq_pkg::*;
#(
   parameter int                    OPCODE_W     = OPCODE_W_DEF,
   parameter logic [OPCODE_W-1:0]   NOP_OPCODE   = NOP_OPCODE_DEF,
   parameter logic [OPCODE_W-1:0]   STORE_OPCODE = STORE_OPCODE_DEF,
   parameter logic [OPCODE_W-1:0]   HALT_OPCODE  = HALT_OPCODE_DEF
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic                is_nop_o,
   output logic                is_store_o,
   output logic                is_halt_o
);

   assign is_nop_o   = (opcode_i == NOP_OPCODE);
   assign is_store_o = (opcode_i == STORE_OPCODE);
   assign is_halt_o  = (opcode_i == HALT_OPCODE);

endmodule

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer with run/halt control, single-step mode,
// memory stalls at Fetch/Memory and a retired-instruction counter.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int                    OPCODE_W     = OPCODE_W_DEF,
   parameter logic [OPCODE_W-1:0]   NOP_OPCODE   = NOP_OPCODE_DEF,
   parameter logic [OPCODE_W-1:0]   STORE_OPCODE = STORE_OPCODE_DEF,
   parameter logic [OPCODE_W-1:0]   HALT_OPCODE  = HALT_OPCODE_DEF,
   parameter int                    ICOUNT_W     = ICOUNT_W_DEF
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   input  logic                Step_Mode,
   input  logic                Stall,
   input  logic [OPCODE_W-1:0] Opcode,
   output logic [2:0]          Stage,
   output logic                NOP_FLAG,
   output logic                WillWriteTo_Memory_H_RF_L,
   output logic                Busy,
   output logic                Halted,
   output logic [ICOUNT_W-1:0] Instr_Count
);

   fsm_state_e          state_q, state_d;
   logic [2:0]          stage_q, stage_d;
   logic                nop_q, nop_d;
   logic                wwm_q, wwm_d;
   logic                halt_pend_q, halt_pend_d;
   logic                busy_q, busy_d;
   logic                halted_q, halted_d;
   logic [ICOUNT_W-1:0] instr_count_q, instr_count_d;

   logic is_nop, is_store, is_halt;

   opcode_flag_decode #(
      .OPCODE_W     (OPCODE_W),
      .NOP_OPCODE   (NOP_OPCODE),
      .STORE_OPCODE (STORE_OPCODE),
      .HALT_OPCODE  (HALT_OPCODE)
   ) u_decode (
      .opcode_i   (Opcode),
      .is_nop_o   (is_nop),
      .is_store_o (is_store),
      .is_halt_o  (is_halt)
   );

   // Next-state and next-output computation for control FSM and stage counter
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      state_d       = state_q;
      stage_d       = stage_q;
      nop_d         = nop_q;
      wwm_d         = wwm_q;
      halt_pend_d   = halt_pend_q;
      busy_d        = busy_q;
      halted_d      = halted_q;
      instr_count_d = instr_count_q;

      unique case (state_q)
         FSM_IDLE, FSM_HALTED: begin
            if (Run) begin
               state_d  = FSM_RUN;
               stage_d  = STAGE_FETCH;
               busy_d   = 1'b1;
               halted_d = 1'b0;
            end
         end

         FSM_RUN: begin
            case (stage_q)
               STAGE_FETCH: begin
                  if (!Stall) stage_d = STAGE_DECODE;
               end
               STAGE_DECODE: begin
                  // Opcode is only valid here, so the qualifiers are captured on this edge
                  stage_d     = STAGE_EXECUTE;
                  nop_d       = is_nop | is_halt;
                  wwm_d       = is_store;
                  halt_pend_d = is_halt;
               end
               STAGE_EXECUTE: begin
                  stage_d = STAGE_MEMORY;
               end
               STAGE_MEMORY: begin
                  if (!Stall) stage_d = STAGE_WRITEBACK;
               end
               STAGE_WRITEBACK: begin
                  instr_count_d = instr_count_q + ICOUNT_W'(1);
                  nop_d         = 1'b0;
                  wwm_d         = 1'b0;
                  halt_pend_d   = 1'b0;
                  if (halt_pend_q) begin
                     state_d  = FSM_HALTED;
                     stage_d  = STAGE_IDLE;
                     busy_d   = 1'b0;
                     halted_d = 1'b1;
                  end else if (Step_Mode) begin
                     state_d = FSM_IDLE;
                     stage_d = STAGE_IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     stage_d = STAGE_FETCH;
                  end
               end
               default: begin
                  // Unreachable stage value: restart the instruction cleanly
                  stage_d = STAGE_FETCH;
               end
            endcase
         end

         default: begin
            state_d  = FSM_IDLE;
            stage_d  = STAGE_IDLE;
            busy_d   = 1'b0;
            halted_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge Clock or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Reset) begin
         state_q       <= FSM_IDLE;
         stage_q       <= STAGE_IDLE;
         nop_q         <= 1'b0;
         wwm_q         <= 1'b0;
         halt_pend_q   <= 1'b0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stage_q       <= stage_d;
         nop_q         <= nop_d;
         wwm_q         <= wwm_d;
         halt_pend_q   <= halt_pend_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign Stage                     = stage_q;
   assign NOP_FLAG                  = nop_q;
   assign WillWriteTo_Memory_H_RF_L = wwm_q;
   assign Busy                      = busy_q;
   assign Halted                    = halted_q;
   assign Instr_Count               = instr_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus randomized
// stimulus compared against an instruction-level reference model.
module tb_stage_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Run = 1'b0;
   logic        Step_Mode = 1'b0;
   logic        Stall = 1'b0;
   logic [3:0]  Opcode = 4'h0;
   logic [2:0]  Stage;
   logic        NOP_FLAG;
   logic        WillWriteTo_Memory_H_RF_L;
   logic        Busy;
   logic        Halted;
   logic [15:0] Instr_Count;

   int errors = 0;
   int checks = 0;

   stage_sequencer dut (
      .Clock                     (Clock),
      .Reset                     (Reset),
      .Run                       (Run),
      .Step_Mode                 (Step_Mode),
      .Stall                     (Stall),
      .Opcode                    (Opcode),
      .Stage                     (Stage),
      .NOP_FLAG                  (NOP_FLAG),
      .WillWriteTo_Memory_H_RF_L (WillWriteTo_Memory_H_RF_L),
      .Busy                      (Busy),
      .Halted                    (Halted),
      .Instr_Count               (Instr_Count)
   );

   always #5 Clock = ~Clock;

   // Reference model: mode 0=idle 1=running 2=halted; stage is position in the instruction
   int m_mode, m_stage, m_count;
   bit m_nop, m_wwm, m_halt_pend;

   wire [22:0] dut_vec = {Stage, NOP_FLAG, WillWriteTo_Memory_H_RF_L, Busy, Halted, Instr_Count};

   function automatic logic [22:0] exp_vec();
      return {3'(m_stage), m_nop, m_wwm, (m_mode == 1), (m_mode == 2), 16'(m_count)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_stage = 0; m_count = 0;
      m_nop = 0; m_wwm = 0; m_halt_pend = 0;
   endtask

   task automatic model_edge();
      if (m_mode != 1) begin
         if (Run) begin
            m_mode  = 1;
            m_stage = 1;
         end
      end else if (Stall && (m_stage == 1 || m_stage == 4)) begin
         // memory not ready: instruction makes no progress
      end else if (m_stage == 5) begin
         m_count = (m_count + 1) % 65536;
         m_nop = 0; m_wwm = 0;
         if (m_halt_pend)    begin m_mode = 2; m_stage = 0; end
         else if (Step_Mode) begin m_mode = 0; m_stage = 0; end
         else                m_stage = 1;
         m_halt_pend = 0;
      end else begin
         if (m_stage == 2) begin
            m_nop       = (Opcode == 4'h0) || (Opcode == 4'hF);
            m_wwm       = (Opcode == 4'h3);
            m_halt_pend = (Opcode == 4'hF);
         end
         m_stage = m_stage + 1;
      end
   endtask

   task automatic step(input logic run, input logic sm, input logic st, input logic [3:0] op);
      @(negedge Clock);
      Run = run; Step_Mode = sm; Stall = st; Opcode = op;
      @(posedge Clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b1; Run = 1'b0; Step_Mode = 1'b0; Stall = 1'b0; Opcode = 4'h0;
      model_reset();
      #3 Reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_vec !== 23'h0) begin
         errors++;
         $display("FAIL reset_state: got %h want 000000", dut_vec);
      end
   endtask

   task automatic test_basic();
      logic [2:0] exp_st [6];
      exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(i == 0, 1'b0, 1'b0, 4'h1);
         checks++;
         if (Stage !== exp_st[i] || NOP_FLAG !== 1'b0 || WillWriteTo_Memory_H_RF_L !== 1'b0) begin
            errors++;
            $display("FAIL basic_seq[%0d]: stage=%0d nop=%b wwm=%b want stage=%0d nop=0 wwm=0",
                     i, Stage, NOP_FLAG, WillWriteTo_Memory_H_RF_L, exp_st[i]);
         end
      end
      checks++;
      if (Instr_Count !== 16'd1 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_count: count=%0d busy=%b want count=1 busy=1", Instr_Count, Busy);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'h1);
      checks++;
      if (dut_vec !== exp_vec() || Stage !== 3'd0 || Instr_Count !== 16'd2) begin
         errors++;
         $display("FAIL basic_stop: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_store();
      logic exp_w [6];
      exp_w = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(i == 0, 1'b0, 1'b0, 4'h3);
         checks++;
         if (WillWriteTo_Memory_H_RF_L !== exp_w[i] || NOP_FLAG !== 1'b0) begin
            errors++;
            $display("FAIL store_wwm[%0d]: wwm=%b nop=%b want wwm=%b nop=0",
                     i, WillWriteTo_Memory_H_RF_L, NOP_FLAG, exp_w[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic       st_pat [10];
      logic [2:0] exp_st [10];
      st_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_st = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
      do_reset();
      step(1'b1, 1'b0, 1'b0, 4'h1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, st_pat[i], 4'h1);
         checks++;
         if (Stage !== exp_st[i] || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL stall_seq[%0d]: stage=%0d vec=%h want stage=%0d vec=%h",
                     i, Stage, dut_vec, exp_st[i], exp_vec());
         end
      end
      checks++;
      if (Instr_Count !== 16'd1) begin
         errors++;
         $display("FAIL stall_count: got %0d want 1", Instr_Count);
      end
   endtask

   task automatic test_halt();
      logic [2:0] exp_st [6];
      logic       exp_n  [6];
      exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
      exp_n  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(i == 0, 1'b0, 1'b0, 4'hF);
         checks++;
         if (Stage !== exp_st[i] || NOP_FLAG !== exp_n[i]) begin
            errors++;
            $display("FAIL halt_seq[%0d]: stage=%0d nop=%b want stage=%0d nop=%b",
                     i, Stage, NOP_FLAG, exp_st[i], exp_n[i]);
         end
      end
      step(1'b0, 1'b0, 1'b0, 4'h1);
      checks++;
      if (Halted !== 1'b1 || Busy !== 1'b0 || Stage !== 3'd0 || Instr_Count !== 16'd1) begin
         errors++;
         $display("FAIL halt_state: halted=%b busy=%b stage=%0d count=%0d want 1 0 0 1",
                  Halted, Busy, Stage, Instr_Count);
      end
      step(1'b1, 1'b0, 1'b0, 4'h1);
      checks++;
      if (Halted !== 1'b0 || Busy !== 1'b1 || Stage !== 3'd1) begin
         errors++;
         $display("FAIL halt_resume: halted=%b busy=%b stage=%0d want 0 1 1", Halted, Busy, Stage);
      end
   endtask

   task automatic test_step_mode();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(i == 0, 1'b1, 1'b0, 4'h1);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL step_pass[%0d]: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      checks++;
      if (Stage !== 3'd0 || Busy !== 1'b0 || Halted !== 1'b0 || Instr_Count !== 16'd1) begin
         errors++;
         $display("FAIL step_idle: stage=%0d busy=%b halted=%b count=%0d want 0 0 0 1",
                  Stage, Busy, Halted, Instr_Count);
      end
      for (int i = 0; i < 6; i++) step(i == 0, 1'b1, 1'b0, 4'hF);
      checks++;
      if (Halted !== 1'b1 || Stage !== 3'd0 || Instr_Count !== 16'd2) begin
         errors++;
         $display("FAIL step_halt: halted=%b stage=%0d count=%0d want 1 0 2", Halted, Stage, Instr_Count);
      end
   endtask

   task automatic test_async_reset_wrap();
      do_reset();
      for (int i = 0; i < 3; i++) step(i == 0, 1'b0, 1'b0, 4'h3);
      checks++;
      if (Stage !== 3'd3 || WillWriteTo_Memory_H_RF_L !== 1'b1) begin
         errors++;
         $display("FAIL async_setup: stage=%0d wwm=%b want 3 1", Stage, WillWriteTo_Memory_H_RF_L);
      end
      Reset = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 23'h0) begin
         errors++;
         $display("FAIL async_reset: got %h want 000000", dut_vec);
      end
      #1 Reset = 1'b0;
      model_reset();
      dut.instr_count_q = 16'hFFFF;
      m_count = 65535;
      for (int i = 0; i < 6; i++) step(i == 0, 1'b1, 1'b0, 4'h1);
      checks++;
      if (Instr_Count !== 16'h0000 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL count_wrap: count=%h vec=%h want 0000 vec=%h", Instr_Count, dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 4))
            0:       op = 4'h0;
            1:       op = 4'h3;
            2:       op = 4'hF;
            default: op = 4'($urandom_range(0, 15));
         endcase
         step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, op);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_store();
      test_stall();
      test_halt();
      test_step_mode();
      test_async_reset_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
